// File: rtl/arbiter_wrr_ack_pkg.sv
// Shared types and helpers for the weighted round-robin arbiter.
package arbiter_wrr_pkg;

  typedef enum logic {ARB_IDLE, ARB_GRANT} arb_state_t;

  // Widest client vector onehot_to_idx accepts; callers zero-extend to this.
  localparam int MAX_CLIENTS = 32;

  function automatic int onehot_to_idx(input logic [MAX_CLIENTS-1:0] oh);
    int idx;
    idx = 0;
    for (int i = 0; i < MAX_CLIENTS; i++) begin
      if (oh[i]) idx = idx | i;
    end
    return idx;
  endfunction

endpackage

// File: rtl/arbiter_wrr_ack_if.sv
// Request/grant bundle between clients (master) and the arbiter (slave).
interface arbiter_wrr_ack_if #(
  parameter int N  = 4,
  parameter int WW = 4,
  parameter int W  = $clog2(N)
);
  logic            block_arb;
  logic [N-1:0]    request;
  logic [N*WW-1:0] cfg_weight;
  logic [N-1:0]    grant_ack;
  logic            grant_valid;
  logic [N-1:0]    grant;
  logic [W-1:0]    grant_id;
  logic [W-1:0]    last_grant_id;

  modport master (
    output block_arb, request, cfg_weight, grant_ack,
    input  grant_valid, grant, grant_id, last_grant_id
  );

  modport slave (
    input  block_arb, request, cfg_weight, grant_ack,
    output grant_valid, grant, grant_id, last_grant_id
  );
endinterface

// File: rtl/arbiter_wrr_ack_pick.sv
// Combinational round-robin pick: first set bit of eligible_i at or above start_i, wrapping.
module arbiter_rr_pick #(
  parameter int N = 4,
  parameter int W = $clog2(N)
) (
  input  logic [N-1:0] eligible_i,
  input  logic [W-1:0] start_i,
  output logic [N-1:0] onehot_o,
  output logic         valid_o
);
  logic [N-1:0] rot;
  logic [N-1:0] low;

  always_comb begin
    // Rotate start_i down to bit 0, isolate the lowest set bit, rotate back.
    rot      = N'({eligible_i, eligible_i} >> start_i);
    low      = rot & (~rot + N'(1));
    onehot_o = N'(({low, low} << start_i) >> N);
    valid_o  = |eligible_i;
  end

endmodule

// File: rtl/arbiter_wrr_ack.sv
// Weighted round-robin arbiter: per-client credits, sticky bursts, grant held until ack.
module arbiter_wrr_ack
  import arbiter_wrr_pkg::*;
#(
  parameter int N            = 4,
  parameter int MAX_WEIGHT   = 15,
  parameter int WW           = $clog2(MAX_WEIGHT + 1),
  parameter int W            = $clog2(N),
  parameter int WAIT_GNT_ACK = 1
) (
  input logic              clk,
  input logic              rst,
  arbiter_wrr_ack_if.slave bus
);

  localparam logic [W-1:0]  LAST_IDX = W'(N - 1);
  localparam logic [WW-1:0] MAXW_V   = WW'(MAX_WEIGHT);

  function automatic logic [WW-1:0] weight_eff(input logic [WW-1:0] w);
    if (w == '0) return WW'(1);
    if (w > MAXW_V) return MAXW_V;
    return w;
  endfunction

  function automatic logic [WW-1:0] credit_dec(input logic [WW-1:0] c);
    return (c == '0) ? '0 : c - WW'(1);
  endfunction

  arb_state_t    state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [W-1:0]  grant_id_q, grant_id_d;
  logic [W-1:0]  last_q, last_d;
  logic [WW-1:0] cred_q [N];
  logic [WW-1:0] cred_d [N];
  logic [WW-1:0] cred_c [N];

  logic         in_grant, ack_hit, complete, withdraw;
  logic [W-1:0] last_c, start;
  logic [N-1:0] elig_raw, elig;
  logic         reload, sticky, arb_en;
  logic [N-1:0] pick_oh;
  logic         pick_vld;

  // Completion effects first, so a WAIT_GNT_ACK=0 re-arbitration sees the updated credits.
  always_comb begin
    in_grant = (state_q == ARB_GRANT);
    ack_hit  = (WAIT_GNT_ACK == 0) || bus.grant_ack[grant_id_q];
    complete = in_grant && ack_hit;
    withdraw = in_grant && !ack_hit && !bus.request[grant_id_q];
    last_c   = complete ? grant_id_q : last_q;
    elig_raw = '0;
    for (int i = 0; i < N; i++) begin
      cred_c[i] = cred_q[i];
      if (complete && (grant_id_q == W'(i))) cred_c[i] = credit_dec(cred_q[i]);
      elig_raw[i] = bus.request[i] && (cred_c[i] != '0);
    end
    reload = (elig_raw == '0);
    elig   = reload ? bus.request : elig_raw;
    // Burst continuation uses pre-reload credit, so an exhausted client yields the round.
    sticky = elig_raw[last_c];
    start  = (last_c == LAST_IDX) ? '0 : last_c + W'(1);
  end

  arbiter_rr_pick #(.N(N), .W(W)) u_pick (
    .eligible_i (elig),
    .start_i    (start),
    .onehot_o   (pick_oh),
    .valid_o    (pick_vld)
  );

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    grant_id_d = grant_id_q;
    last_d     = last_c;
    for (int i = 0; i < N; i++) cred_d[i] = cred_c[i];
    arb_en = !bus.block_arb && (bus.request != '0) &&
             ((state_q == ARB_IDLE) || ((WAIT_GNT_ACK == 0) && in_grant));

    if (complete || withdraw) begin
      state_d = ARB_IDLE;
      grant_d = '0;
    end

    if (arb_en && (sticky || pick_vld)) begin
      if (reload) begin
        for (int i = 0; i < N; i++) cred_d[i] = weight_eff(bus.cfg_weight[i*WW +: WW]);
      end
      state_d = ARB_GRANT;
      if (sticky) begin
        grant_d    = N'(1) << last_c;
        grant_id_d = last_c;
      end else begin
        grant_d    = pick_oh;
        grant_id_d = W'(onehot_to_idx(MAX_CLIENTS'(pick_oh)));
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ARB_IDLE;
      grant_q    <= '0;
      grant_id_q <= '0;
      last_q     <= LAST_IDX;
      for (int i = 0; i < N; i++) cred_q[i] <= '0;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      grant_id_q <= grant_id_d;
      last_q     <= last_d;
      for (int i = 0; i < N; i++) cred_q[i] <= cred_d[i];
    end
  end

  assign bus.grant_valid   = (state_q == ARB_GRANT);
  assign bus.grant         = grant_q;
  assign bus.grant_id      = grant_id_q;
  assign bus.last_grant_id = last_q;

endmodule
